// File: rtl/ofifo_drain_pkg.sv
// Shared types and constants for the OFIFO drain / SFP stage.
package ofifo_drain_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ACCUM    = 3'd1,
    FINAL    = 3'd2,
    WAIT_OUT = 3'd3,
    DONE     = 3'd4
  } state_e;

  localparam int PSUM_BW = 16;
  localparam logic signed [PSUM_BW-1:0] SAT_MAX = {1'b0, {(PSUM_BW-1){1'b1}}};
  localparam logic signed [PSUM_BW-1:0] SAT_MIN = {1'b1, {(PSUM_BW-1){1'b0}}};

endpackage

// File: rtl/ofifo_drain_sfp_lane.sv
// One SFP lane: first-pass select, saturating accumulate, optional ReLU.
// Purely combinational.
module sfp_lane
  import ofifo_drain_pkg::*;
#(
  parameter int psum_bw = PSUM_BW
) (
  input  logic                      first,
  input  logic                      relu_en,
  input  logic signed [psum_bw-1:0] acc,
  input  logic signed [psum_bw-1:0] lane,
  output logic signed [psum_bw-1:0] acc_nxt,
  output logic signed [psum_bw-1:0] out_val
);

  logic signed [psum_bw:0] sum;
  logic                    ovf;

  always_comb begin
    sum = {acc[psum_bw-1], acc} + {lane[psum_bw-1], lane};
    // Overflow shows up as disagreement between the guard bit and the sign bit.
    ovf = sum[psum_bw] ^ sum[psum_bw-1];
    if (first) begin
      acc_nxt = lane;
    end else if (ovf) begin
      acc_nxt = sum[psum_bw] ? SAT_MIN : SAT_MAX;
    end else begin
      acc_nxt = sum[psum_bw-1:0];
    end
    out_val = (relu_en && acc_nxt[psum_bw-1]) ? '0 : acc_nxt;
  end

endmodule

// File: rtl/ofifo_drain_sfp.sv
// Drains corelet OFIFO, accumulates psums across passes, emits finished vectors.
// One pop per cycle; output register stalls pops while full and not accepted.
module ofifo_drain_sfp
  import ofifo_drain_pkg::*;
#(
  parameter int col     = 8,
  parameter int psum_bw = PSUM_BW,
  parameter int max_vec = 16,
  parameter int vec_aw  = 4,
  parameter int pass_w  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [vec_aw:0]          num_vec,
  input  logic [pass_w-1:0]        num_pass,
  input  logic                     relu_en,
  input  logic                     ofifo_valid,
  input  logic [col*psum_bw-1:0]   ofifo_out,
  output logic                     ofifo_rd,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [col*psum_bw-1:0]   out_data,
  output logic [vec_aw-1:0]        out_addr,
  output logic                     busy,
  output logic                     done
);

  localparam logic [vec_aw:0]   VEC_ONE  = 1;
  localparam logic [vec_aw-1:0] CNT_ONE  = 1;
  localparam logic [pass_w-1:0] PASS_ONE = 1;
  localparam logic [pass_w-1:0] PASS_TWO = 2;

  state_e state, state_nxt;

  logic [vec_aw:0]        num_vec_q;
  logic [pass_w-1:0]      num_pass_q;
  logic                   relu_q;
  logic [vec_aw-1:0]      vec_cnt;
  logic [pass_w-1:0]      pass_cnt;

  logic [col*psum_bw-1:0] acc_mem [max_vec];
  logic [col*psum_bw-1:0] acc_rd;
  logic [col*psum_bw-1:0] acc_nxt;
  logic [col*psum_bw-1:0] res;

  logic pop;
  logic last_vec;
  logic first_pass;
  logic last_acc_pass;

  assign pop           = ofifo_rd;
  assign acc_rd        = acc_mem[vec_cnt];
  assign last_vec      = ({1'b0, vec_cnt} == (num_vec_q - VEC_ONE));
  assign first_pass    = (pass_cnt == '0);
  assign last_acc_pass = (pass_cnt == (num_pass_q - PASS_TWO));

  for (genvar i = 0; i < col; i++) begin : g_lane
    sfp_lane #(.psum_bw(psum_bw)) u_lane (
      .first   (first_pass),
      .relu_en (relu_q),
      .acc     (acc_rd[i*psum_bw +: psum_bw]),
      .lane    (ofifo_out[i*psum_bw +: psum_bw]),
      .acc_nxt (acc_nxt[i*psum_bw +: psum_bw]),
      .out_val (res[i*psum_bw +: psum_bw])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (num_pass > PASS_ONE) ? ACCUM : FINAL;
        end
      end
      ACCUM: begin
        if (pop && last_vec && last_acc_pass) begin
          state_nxt = FINAL;
        end
      end
      FINAL: begin
        if (pop && last_vec) begin
          state_nxt = WAIT_OUT;
        end
      end
      WAIT_OUT: begin
        if (out_valid && out_ready) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ofifo_rd = 1'b0;
    busy     = (state != IDLE);
    done     = (state == DONE);
    case (state)
      ACCUM:   ofifo_rd = ofifo_valid;
      FINAL:   ofifo_rd = ofifo_valid && (!out_valid || out_ready);
      default: ofifo_rd = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      num_vec_q  <= '0;
      num_pass_q <= '0;
      relu_q     <= 1'b0;
      vec_cnt    <= '0;
      pass_cnt   <= '0;
    end else if (state == IDLE && start) begin
      num_vec_q  <= num_vec;
      num_pass_q <= num_pass;
      relu_q     <= relu_en;
      vec_cnt    <= '0;
      pass_cnt   <= '0;
    end else if (pop) begin
      if (last_vec) begin
        vec_cnt  <= '0;
        pass_cnt <= pass_cnt + PASS_ONE;
      end else begin
        vec_cnt  <= vec_cnt + CNT_ONE;
      end
    end
  end

  // Accumulator contents need no reset: pass 0 overwrites every entry used.
  always_ff @(posedge clk) begin
    if (pop && state == ACCUM) begin
      acc_mem[vec_cnt] <= acc_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
    end else if (state == FINAL && pop) begin
      out_valid <= 1'b1;
      out_data  <= res;
      out_addr  <= vec_cnt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ofifo_drain_sfp.sv
// Randomized bench for ofifo_drain_sfp against a pass-summing reference model.
module tb_ofifo_drain_sfp;

  localparam int COL  = 8;
  localparam int BW   = 16;
  localparam int W    = COL * BW;
  localparam int MAXV = (1 << (BW - 1)) - 1;
  localparam int MINV = -(1 << (BW - 1));

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [4:0]    num_vec = '0;
  logic [3:0]    num_pass = '0;
  logic          relu_en = 1'b0;
  logic          ofifo_valid = 1'b0;
  logic [W-1:0]  ofifo_out = '0;
  logic          ofifo_rd;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [3:0]    out_addr;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_d[$];
  int           exp_a[$];

  ofifo_drain_sfp dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_vec     (num_vec),
    .num_pass    (num_pass),
    .relu_en     (relu_en),
    .ofifo_valid (ofifo_valid),
    .ofifo_out   (ofifo_out),
    .ofifo_rd    (ofifo_rd),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_addr    (out_addr),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] splat(input int v);
    logic [W-1:0] r;
    for (int i = 0; i < COL; i++) r[i*BW +: BW] = v[BW-1:0];
    return r;
  endfunction

  function automatic logic [W-1:0] rand_vec(input bit big);
    logic [W-1:0] r;
    int           v;
    for (int i = 0; i < COL; i++) begin
      v = big ? int'($urandom) : int'($urandom_range(0, 400)) - 200;
      r[i*BW +: BW] = v[BW-1:0];
    end
    return r;
  endfunction

  // Expected output per vector: saturating sum over passes, then optional ReLU.
  function automatic void model(input int nv, input int np, input bit relu);
    logic [W-1:0]         vec;
    logic [W-1:0]         o;
    logic signed [BW-1:0] lv;
    int                   s;
    for (int v = 0; v < nv; v++) begin
      o = '0;
      for (int l = 0; l < COL; l++) begin
        s = 0;
        for (int p = 0; p < np; p++) begin
          vec = fifo_q[p*nv + v];
          lv  = vec[l*BW +: BW];
          s   = (p == 0) ? int'(lv) : s + int'(lv);
          if (s > MAXV) s = MAXV;
          if (s < MINV) s = MINV;
        end
        if (relu && s < 0) s = 0;
        o[l*BW +: BW] = s[BW-1:0];
      end
      exp_d.push_back(o);
      exp_a.push_back(v);
    end
  endfunction

  task automatic run_tile(input int nv, input int np, input bit relu,
                          input int stall, input bit rnd, input bit abort1);
    int           cyc = 0;
    int           outs = 0;
    int           dones = 0;
    int           stall_left = stall;
    bit           stalled = 1'b0;
    bit           aborted = 1'b0;
    logic [W-1:0] held_d = '0;
    logic [3:0]   held_a = '0;

    model(nv, np, relu);
    @(negedge clk);
    start = 1'b1; num_vec = 5'(nv); num_pass = 4'(np); relu_en = relu;
    ofifo_valid = 1'b0; out_ready = 1'b0;
    #1 chk("idle_busy", busy, 0);

    while (dones == 0 && !aborted && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      // Start pulses and config changes mid-tile must be ignored.
      start = rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
      if (rnd) begin
        num_vec  = 5'($urandom_range(1, 16));
        num_pass = 4'($urandom_range(1, 15));
        relu_en  = 1'($urandom_range(0, 1));
      end
      ofifo_valid = (fifo_q.size() > 0) && (!rnd || $urandom_range(0, 3) != 0);
      if (ofifo_valid) ofifo_out = fifo_q[0];
      else             ofifo_out = {4{$urandom}};
      if (out_valid && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      #1;
      chk("busy", busy, 1);
      chk("rd", ofifo_rd, ofifo_valid && (!out_valid || out_ready));
      if (stalled && out_valid) begin
        chk("stable_data", out_data, held_d);
        chk("stable_addr", out_addr, held_a);
      end
      stalled = out_valid && !out_ready;
      held_d  = out_data;
      held_a  = out_addr;
      if (ofifo_rd && ofifo_valid) fifo_q.delete(0);
      if (out_valid && out_ready) begin
        if (exp_d.size() == 0) begin
          chk("extra_out", 1, 0);
        end else begin
          chk("out_addr", out_addr, exp_a.pop_front());
          chk("out_data", out_data, exp_d.pop_front());
        end
        outs++;
        if (abort1 && outs == 1) aborted = 1'b1;
      end
      if (done) dones++;
    end

    if (aborted) begin
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_addr", out_addr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rd", ofifo_rd, 0);
      @(negedge clk);
      reset = 1'b1;
      start = 1'b0; ofifo_valid = 1'b0;
      fifo_q.delete(); exp_d.delete(); exp_a.delete();
      @(negedge clk);
      #1 chk("post_rst_done", done, 0);
      return;
    end

    if (cyc >= 4000) chk("timeout", 0, 1);
    chk("done_once", dones, 1);
    chk("num_outs", outs, nv);
    chk("fifo_drained", fifo_q.size(), 0);
    @(negedge clk);
    start = 1'b0; ofifo_valid = 1'b0;
    #1;
    chk("end_busy", busy, 0);
    chk("end_done", done, 0);
    chk("end_valid", out_valid, 0);
  endtask

  initial begin
    int nv, np;
    bit big;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rd0", ofifo_rd, 0);
    chk("rst_valid0", out_valid, 0);
    chk("rst_data0", out_data, 0);
    chk("rst_addr0", out_addr, 0);
    chk("rst_busy0", busy, 0);
    chk("rst_done0", done, 0);
    reset = 1'b1;

    fifo_q = '{splat(5), splat(-3)};
    run_tile(2, 1, 0, 0, 0, 0);

    for (int p = 0; p < 3; p++) begin
      fifo_q.push_back(splat(10));
      fifo_q.push_back(splat(1));
    end
    run_tile(2, 3, 0, 0, 0, 0);

    fifo_q = '{splat(20000), splat(-20000), splat(20000), splat(-20000)};
    run_tile(2, 2, 0, 0, 0, 0);

    fifo_q = '{splat(-7), splat(9)};
    run_tile(2, 1, 1, 0, 0, 0);
    fifo_q = '{splat(-7), splat(9)};
    run_tile(2, 1, 0, 0, 0, 0);

    for (int i = 0; i < 6; i++) fifo_q.push_back(rand_vec(1'b1));
    run_tile(6, 1, 0, 5, 0, 0);

    for (int i = 0; i < 4; i++) fifo_q.push_back(rand_vec(1'b0));
    run_tile(4, 1, 0, 0, 0, 1);
    fifo_q = '{splat(4)};
    run_tile(1, 1, 0, 0, 0, 0);

    for (int t = 0; t < 25; t++) begin
      nv  = $urandom_range(1, 16);
      np  = ($urandom_range(0, 5) == 0) ? 15 : $urandom_range(1, 4);
      big = 1'($urandom_range(0, 1));
      for (int i = 0; i < nv * np; i++) fifo_q.push_back(rand_vec(big));
      run_tile(nv, np, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
